// File: rtl/io_bank_arb_pkg.sv
// Shared types and constants for the io_bank_arbiter pin-sharing block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package io_bank_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        OWN  = 2'd2
    } state_t;

    // Per-pin values the bank sees while nobody owns it: released, driving 0.
    localparam logic RT_RST_BIT = 1'b1;
    localparam logic RO_RST_BIT = 1'b0;

    // Ceiling log2 with a floor of 1 so every counter gets at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/io_bank_arb_if.sv
// Bundles requester-side and bank-side signals of the pin-sharing arbiter.
// Latency: n/a (wires only).
// Backpressure: none; req is a level request, gnt is the only answer.
interface io_bank_arb_if #(
    parameter int C_NUM_REQ    = 2,
    parameter int C_NUM_OF_PIN = 8
);
    logic [C_NUM_REQ-1:0]              req;
    logic [C_NUM_REQ-1:0]              gnt;
    logic [C_NUM_REQ*C_NUM_OF_PIN-1:0] req_o;
    logic [C_NUM_REQ*C_NUM_OF_PIN-1:0] req_t;
    logic [C_NUM_OF_PIN-1:0]           ro;
    logic [C_NUM_OF_PIN-1:0]           rt;
    logic [C_NUM_OF_PIN-1:0]           ri;
    logic [C_NUM_OF_PIN-1:0]           li_sync;
    logic                              timeout;

    // Requesters plus the pad bank, as seen from outside the arbiter.
    modport master (
        output req, req_o, req_t, ri,
        input  gnt, ro, rt, li_sync, timeout
    );

    // The arbiter itself.
    modport slave (
        input  req, req_o, req_t, ri,
        output gnt, ro, rt, li_sync, timeout
    );
endinterface

// File: rtl/io_rr_pick.sv
// Round-robin first-set-bit finder: first eligible request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; vld low when no eligible request is present.
module io_rr_pick #(
    parameter int C_NUM_REQ = 2,
    parameter int C_PW      = 1
) (
    input  logic [C_NUM_REQ-1:0] req,
    input  logic [C_NUM_REQ-1:0] eligible,
    input  logic [C_PW-1:0]      ptr,
    output logic [C_NUM_REQ-1:0] pick,
    output logic                 vld
);

    logic [C_NUM_REQ-1:0] cand;

    assign cand = req & eligible;

    // Walk the requesters starting at ptr; the first candidate wins.
    always_comb begin
        pick = '0;
        vld  = 1'b0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % C_NUM_REQ;
            if (!vld && cand[idx]) begin
                pick[idx] = 1'b1;
                vld       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_bank_arbiter.sv
// Round-robin owner of one tri-state pin bank with a forced high-Z turnaround; optional IO_ARB_TIMEOUT_EN revokes long ownerships.
// Latency: owner req_o/req_t reach ro/rt 1 cycle later; grant 1 IDLE + C_TURNAROUND cycles after request; li_sync 2 cycles after ri.
// Backpressure: requesters hold req until gnt; owner keeps the bank while req stays high (or until timeout, when enabled).
module io_bank_arbiter
    import io_bank_arb_pkg::*;
#(
    parameter int C_NUM_OF_PIN = 8,
    parameter int C_NUM_REQ    = 2,
    parameter int C_TURNAROUND = 2,
    parameter int C_TIMEOUT    = 1024
) (
    input logic         clk,
    input logic         rst,
    io_bank_arb_if.slave bus
);

    localparam int PW = clog2(C_NUM_REQ);
    localparam int CW = clog2(C_TURNAROUND + 1);

    localparam logic [C_NUM_OF_PIN-1:0] RT_IDLE = {C_NUM_OF_PIN{RT_RST_BIT}};
    localparam logic [C_NUM_OF_PIN-1:0] RO_IDLE = {C_NUM_OF_PIN{RO_RST_BIT}};
    localparam logic [C_NUM_REQ-1:0]    GNT_ONE = {{(C_NUM_REQ-1){1'b0}}, 1'b1};

    state_t                  state;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           owner;
    logic [PW-1:0]           next_ptr;
    logic [CW-1:0]           tcnt;
    logic [C_NUM_REQ-1:0]    gnt_q;
    logic [C_NUM_OF_PIN-1:0] ro_q;
    logic [C_NUM_OF_PIN-1:0] rt_q;
    logic                    timeout_q;
    logic [C_NUM_OF_PIN-1:0] sync1;
    logic [C_NUM_OF_PIN-1:0] sync2;
    logic [C_NUM_REQ-1:0]    eligible;
    logic [C_NUM_REQ-1:0]    pick;
    logic                    pick_vld;
    logic [PW-1:0]           pick_idx;

`ifdef IO_ARB_TIMEOUT_EN
    localparam int OW = clog2(C_TIMEOUT);
    logic [OW-1:0]        ocnt;
    logic [C_NUM_REQ-1:0] elig_q;
    assign eligible = elig_q;
`else
    assign eligible = '1;
`endif

    io_rr_pick #(
        .C_NUM_REQ (C_NUM_REQ),
        .C_PW      (PW)
    ) u_pick (
        .req      (bus.req),
        .eligible (eligible),
        .ptr      (ptr),
        .pick     (pick),
        .vld      (pick_vld)
    );

    // One-hot pick to requester index.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    // The requester after the current owner gets first look next time.
    assign next_ptr = (int'(owner) == C_NUM_REQ - 1) ? '0 : owner + 1'b1;

    // Ownership FSM with registered grant and pin mux.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            tcnt      <= '0;
            gnt_q     <= '0;
            ro_q      <= RO_IDLE;
            rt_q      <= RT_IDLE;
            timeout_q <= 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
            ocnt      <= '0;
            elig_q    <= '1;
`endif
        end else begin
            timeout_q <= 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
            // A revoked requester earns eligibility back by dropping req once.
            for (int k = 0; k < C_NUM_REQ; k++) begin
                if (!bus.req[k]) begin
                    elig_q[k] <= 1'b1;
                end
            end
`endif
            case (state)
                IDLE: begin
                    gnt_q <= '0;
                    ro_q  <= RO_IDLE;
                    rt_q  <= RT_IDLE;
                    if (pick_vld) begin
                        owner <= pick_idx;
                        tcnt  <= '0;
                        state <= TURN;
                    end
                end
                TURN: begin
                    ro_q <= RO_IDLE;
                    rt_q <= RT_IDLE;
                    if (!bus.req[owner]) begin
                        state <= IDLE;
                    end else if (tcnt == CW'(C_TURNAROUND - 1)) begin
                        gnt_q <= GNT_ONE << owner;
                        state <= OWN;
`ifdef IO_ARB_TIMEOUT_EN
                        ocnt  <= '0;
`endif
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                OWN: begin
                    if (!bus.req[owner]) begin
                        gnt_q <= '0;
                        ro_q  <= RO_IDLE;
                        rt_q  <= RT_IDLE;
                        ptr   <= next_ptr;
                        state <= IDLE;
`ifdef IO_ARB_TIMEOUT_EN
                    end else if (ocnt == OW'(C_TIMEOUT - 1)) begin
                        gnt_q         <= '0;
                        ro_q          <= RO_IDLE;
                        rt_q          <= RT_IDLE;
                        ptr           <= next_ptr;
                        timeout_q     <= 1'b1;
                        elig_q[owner] <= 1'b0;
                        state         <= IDLE;
`endif
                    end else begin
                        ro_q <= bus.req_o[owner*C_NUM_OF_PIN +: C_NUM_OF_PIN];
                        rt_q <= bus.req_t[owner*C_NUM_OF_PIN +: C_NUM_OF_PIN];
`ifdef IO_ARB_TIMEOUT_EN
                        ocnt <= ocnt + 1'b1;
`endif
                    end
                end
                default: begin
                    gnt_q <= '0;
                    ro_q  <= RO_IDLE;
                    rt_q  <= RT_IDLE;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Two-flop synchroniser on the raw pin inputs; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.ri;
            sync2 <= sync1;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.ro      = ro_q;
    assign bus.rt      = rt_q;
    assign bus.timeout = timeout_q;
    assign bus.li_sync = sync2;

endmodule

// File: tb/tb_io_bank_arbiter.sv
// Bench for io_bank_arbiter: scoreboard of expected grant order plus per-scenario pin checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_io_bank_arbiter;

    localparam int NR = 2;
    localparam int NP = 4;
    localparam int TA = 2;
    localparam int TO = 16;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   exp_q[$];
    logic mon_en;
    logic [NR-1:0] prev_gnt;

    io_bank_arb_if #(.C_NUM_REQ(NR), .C_NUM_OF_PIN(NP)) bus ();

    io_bank_arbiter #(
        .C_NUM_OF_PIN (NP),
        .C_NUM_REQ    (NR),
        .C_TURNAROUND (TA),
        .C_TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle to the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_data(input logic [NP-1:0] o0, input logic [NP-1:0] t0,
                            input logic [NP-1:0] o1, input logic [NP-1:0] t1);
        bus.req_o = {o1, o0};
        bus.req_t = {t1, t0};
    endtask

    // Wait (bounded) until gnt shows the wanted value; returns cycles waited.
    task automatic wait_gnt(input logic [NR-1:0] want, input int budget, output int waited);
        waited = 0;
        while (bus.gnt !== want && waited < budget) begin
            step();
            waited++;
        end
    endtask

    // Grant-order scoreboard plus idle-pin invariant, checked every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_gnt == '0 && bus.gnt != '0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL grant_order: got gnt=%b, no grant expected", bus.gnt);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (bus.gnt !== (NR'(1) << e)) begin
                        miscompares++;
                        $display("FAIL grant_order: got gnt=%b want %b", bus.gnt, NR'(1) << e);
                    end
                end
            end
            vectors++;
            if (bus.gnt === '0 && (bus.rt !== 4'hF || bus.ro !== 4'h0)) begin
                miscompares++;
                $display("FAIL idle_pins: got rt=%h ro=%h want rt=f ro=0", bus.rt, bus.ro);
            end
            vectors++;
            if (!$onehot0(bus.gnt)) begin
                miscompares++;
                $display("FAIL gnt_onehot: got gnt=%b", bus.gnt);
            end
`ifndef IO_ARB_TIMEOUT_EN
            vectors++;
            if (bus.timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_tied: got %b want 0", bus.timeout);
            end
`endif
            prev_gnt = bus.gnt;
        end
    end

    task automatic test_reset();
        int w;
        rst = 1'b1;
        bus.req = 2'b11;
        step();
        mon_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            vectors++;
            if (bus.gnt !== 2'b00 || bus.rt !== 4'hF || bus.ro !== 4'h0 || bus.li_sync !== 4'h0) begin
                miscompares++;
                $display("FAIL reset_vals: got gnt=%b rt=%h ro=%h li=%h want 00 f 0 0",
                         bus.gnt, bus.rt, bus.ro, bus.li_sync);
            end
            if (c < 2) step();
        end
        exp_q.push_back(0);
        rst = 1'b0;
        wait_gnt(2'b01, 20, w);
        vectors++;
        if (bus.gnt !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b want 01", bus.gnt);
        end
        bus.req = 2'b00;
        wait_gnt(2'b00, 10, w);
        step();
    endtask

    task automatic test_single_owner();
        logic [NR-1:0] g_exp [4];
        g_exp[0] = 2'b00; g_exp[1] = 2'b00; g_exp[2] = 2'b01; g_exp[3] = 2'b01;
        set_data(4'hA, 4'h0, 4'h5, 4'h3);
        exp_q.push_back(0);
        bus.req = 2'b01;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if (bus.gnt !== g_exp[c]) begin
                miscompares++;
                $display("FAIL single_gnt_timing: edge %0d got %b want %b", c + 1, bus.gnt, g_exp[c]);
            end
        end
        vectors++;
        if (bus.ro !== 4'hA || bus.rt !== 4'h0) begin
            miscompares++;
            $display("FAIL single_pins: got ro=%h rt=%h want a 0", bus.ro, bus.rt);
        end
        set_data(4'h3, 4'h8, 4'h5, 4'h3);
        step();
        vectors++;
        if (bus.ro !== 4'h3 || bus.rt !== 4'h8) begin
            miscompares++;
            $display("FAIL single_latency: got ro=%h rt=%h want 3 8", bus.ro, bus.rt);
        end
        bus.req = 2'b00;
        step();
        vectors++;
        if (bus.gnt !== 2'b00 || bus.rt !== 4'hF || bus.ro !== 4'h0) begin
            miscompares++;
            $display("FAIL single_release: got gnt=%b rt=%h ro=%h want 00 f 0", bus.gnt, bus.rt, bus.ro);
        end
        step();
    endtask

    task automatic test_handover();
        int w;
        int gap;
        set_data(4'hC, 4'h0, 4'h9, 4'h6);
        exp_q.push_back(0);
        exp_q.push_back(1);
        bus.req = 2'b01;
        step();
        bus.req = 2'b11;
        wait_gnt(2'b01, 20, w);
        for (int c = 0; c < 5; c++) begin
            step();
            vectors++;
            if (bus.gnt !== 2'b01 || bus.ro !== 4'hC || bus.rt !== 4'h0) begin
                miscompares++;
                $display("FAIL handover_owner0: got gnt=%b ro=%h rt=%h want 01 c 0", bus.gnt, bus.ro, bus.rt);
            end
        end
        bus.req = 2'b10;
        gap = 0;
        step();
        while (bus.gnt === 2'b00 && gap < 20) begin
            gap++;
            step();
        end
        vectors++;
        if (gap != 1 + TA) begin
            miscompares++;
            $display("FAIL handover_gap: got %0d cycles want %0d", gap, 1 + TA);
        end
        vectors++;
        if (bus.gnt !== 2'b10 || bus.rt !== 4'hF) begin
            miscompares++;
            $display("FAIL handover_grant1: got gnt=%b rt=%h want 10 f", bus.gnt, bus.rt);
        end
        step();
        vectors++;
        if (bus.ro !== 4'h9 || bus.rt !== 4'h6) begin
            miscompares++;
            $display("FAIL handover_pins1: got ro=%h rt=%h want 9 6", bus.ro, bus.rt);
        end
        bus.req = 2'b00;
        wait_gnt(2'b00, 10, w);
        step();
    endtask

    task automatic test_fairness();
        int w;
        for (int g = 0; g < 6; g++) exp_q.push_back(g % 2);
        for (int g = 0; g < 6; g++) begin
            bus.req = 2'b11;
            w = 0;
            while (bus.gnt === 2'b00 && w < 20) begin
                step();
                w++;
            end
            vectors++;
            if (bus.gnt !== (NR'(1) << (g % 2))) begin
                miscompares++;
                $display("FAIL fairness_round%0d: got %b want %b", g, bus.gnt, NR'(1) << (g % 2));
            end
            step();
            step();
            bus.req = 2'b00;
            wait_gnt(2'b00, 10, w);
            step();
        end
    endtask

    task automatic test_sync_reset();
        int w;
        bus.ri = 4'h5;
        step();
        vectors++;
        if (bus.li_sync !== 4'h0) begin
            miscompares++;
            $display("FAIL sync_one_edge: got %h want 0", bus.li_sync);
        end
        step();
        vectors++;
        if (bus.li_sync !== 4'h5) begin
            miscompares++;
            $display("FAIL sync_two_edges: got %h want 5", bus.li_sync);
        end
        set_data(4'h7, 4'h0, 4'h1, 4'h1);
        exp_q.push_back(0);
        bus.req = 2'b01;
        wait_gnt(2'b01, 20, w);
        step();
        vectors++;
        if (bus.rt !== 4'h0 || bus.ro !== 4'h7) begin
            miscompares++;
            $display("FAIL sync_owner_pins: got rt=%h ro=%h want 0 7", bus.rt, bus.ro);
        end
        rst = 1'b1;
        step();
        vectors++;
        if (bus.rt !== 4'hF || bus.gnt !== 2'b00 || bus.ro !== 4'h0 || bus.li_sync !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_mid_own: got rt=%h gnt=%b ro=%h li=%h want f 00 0 0",
                     bus.rt, bus.gnt, bus.ro, bus.li_sync);
        end
        exp_q.push_back(0);
        rst = 1'b0;
        wait_gnt(2'b01, 20, w);
        vectors++;
        if (bus.gnt !== 2'b01) begin
            miscompares++;
            $display("FAIL regrant_after_rst: got %b want 01", bus.gnt);
        end
        bus.req = 2'b00;
        wait_gnt(2'b00, 10, w);
        step();
    endtask

`ifdef IO_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int w;
        int n;
        set_data(4'h2, 4'h0, 4'h4, 4'h0);
        exp_q.push_back(0);
        bus.req = 2'b01;
        wait_gnt(2'b01, 20, w);
        n = 0;
        while (bus.gnt === 2'b01 && n < 40) begin
            n++;
            step();
        end
        vectors++;
        if (n != TO) begin
            miscompares++;
            $display("FAIL timeout_own_cycles: got %0d want %0d", n, TO);
        end
        vectors++;
        if (bus.timeout !== 1'b1 || bus.gnt !== 2'b00 || bus.rt !== 4'hF) begin
            miscompares++;
            $display("FAIL timeout_revoke: got to=%b gnt=%b rt=%h want 1 00 f", bus.timeout, bus.gnt, bus.rt);
        end
        step();
        vectors++;
        if (bus.timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_pulse_len: got %b want 0", bus.timeout);
        end
        for (int c = 0; c < 8; c++) step();
        vectors++;
        if (bus.gnt !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_inelig: got %b want 00", bus.gnt);
        end
        exp_q.push_back(1);
        bus.req = 2'b11;
        wait_gnt(2'b10, 20, w);
        vectors++;
        if (bus.gnt !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_other_gnt: got %b want 10", bus.gnt);
        end
        bus.req = 2'b00;
        step();
        exp_q.push_back(0);
        bus.req = 2'b01;
        wait_gnt(2'b01, 20, w);
        vectors++;
        if (bus.gnt !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_reelig: got %b want 01", bus.gnt);
        end
        bus.req = 2'b00;
        wait_gnt(2'b00, 10, w);
        step();
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        prev_gnt    = '0;
        rst         = 1'b1;
        bus.req     = '0;
        bus.ri      = '0;
        set_data(4'h0, 4'hF, 4'h0, 4'hF);
        @(negedge clk);
        test_reset();
        test_single_owner();
        test_handover();
        test_fairness();
        test_sync_reset();
`ifdef IO_ARB_TIMEOUT_EN
        test_timeout();
`endif
        step();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL grants_missing: got %0d outstanding want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop if something wedges beyond every bounded wait.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
